// File: rtl/c_rx_pkg.sv
// ---------------------------------------------------------------------------
// c_rx_pkg
// Shared types and constants for the c-line receiver.
//   rxState_t      : receiver FSM states
//   DEF_*          : default bit timing, payload width, parity and queue size
//   parityWidth()  : number of parity bits carried in a frame (0 or 1)
// ---------------------------------------------------------------------------
package c_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rxState_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_PARITY_EN    = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  // A frame carries a single even-parity bit when parity is enabled.
  function automatic int parityWidth(input int parityEn);
    return (parityEn != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/c_rx_fifo.sv
// ---------------------------------------------------------------------------
// c_rx_fifo
// First-word-fall-through queue for received words.
//   i_clk, i_rstn : clock, synchronous active-low reset (pointers only)
//   i_push        : write i_wrData (accepted when not full, or full with pop)
//   i_pop         : remove head word (ignored while empty)
//   o_rdData      : head word, 0 while empty
//   o_full        : all entries occupied
//   o_empty       : no entries
// ---------------------------------------------------------------------------
module c_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wrData,
  output logic [WIDTH-1:0] o_rdData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doPush;
  logic             w_doPop;

  // The extra top pointer bit tells a full queue apart from an empty one
  // when the index bits coincide.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                    (r_wrPtr[AW] != r_rdPtr[AW]);
  assign w_doPop  = i_pop & ~o_empty;
  // A pop frees the head slot in the same cycle, so a full queue can still
  // accept a push when it is being drained.
  assign w_doPush = i_push & (~o_full | w_doPop);

  assign o_rdData = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

  // Read and write pointers advance independently on accepted pops/pushes.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is decided by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
  end

endmodule

// File: rtl/c_line_rx.sv
// ---------------------------------------------------------------------------
// c_line_rx
// Oversampling serial receiver for the c line (start, data LSB first,
// optional even parity, stop) feeding a small FWFT receive queue.
//   i_clk, i_rstn  : clock, synchronous active-low reset
//   i_c            : serial line, idle high
//   i_rd_en        : pop request, honoured only while o_rd_valid = 1
//   o_rd_data      : head of queue, 0 when empty
//   o_rd_valid     : queue not empty
//   o_parity_err   : one-cycle pulse, frame dropped on parity mismatch
//   o_frame_err    : one-cycle pulse, frame dropped on a low stop bit
//   o_overflow     : one-cycle pulse, good frame dropped because queue full
// ---------------------------------------------------------------------------
module c_line_rx
  import c_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = DEF_PARITY_EN,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_c,
  input  logic                 i_rd_en,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int PAR_W = parityWidth(PARITY_EN);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_BITS - 1);

  rxState_t             r_state;
  rxState_t             w_stateNext;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_cs;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parMis;
  logic                 r_parityErr;
  logic                 r_frameErr;
  logic                 r_overflow;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_setParityErr;
  logic                 w_setFrameErr;
  logic                 w_setOverflow;

  assign w_cs         = r_sync2;
  assign o_rd_valid   = ~w_empty;
  assign w_pop        = i_rd_en & ~w_empty;
  assign o_parity_err = r_parityErr;
  assign o_frame_err  = r_frameErr;
  assign o_overflow   = r_overflow;

  // The start bit is sampled half a bit after the falling edge is seen,
  // every later bit one full bit period after the previous sample.
  assign w_tick = (r_state == ST_START) ? (r_cnt == CNT_HALF_LAST)
                                        : (r_cnt == CNT_FULL_LAST);

  // State register for the frame decoder.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state and per-frame decisions; the queue and error pulses are only
  // touched at the stop sample so a frame is either kept or dropped whole.
  always_comb begin
    w_stateNext    = r_state;
    w_push         = 1'b0;
    w_setParityErr = 1'b0;
    w_setFrameErr  = 1'b0;
    w_setOverflow  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_cs) w_stateNext = ST_START;
      end
      ST_START: begin
        if (w_tick) w_stateNext = w_cs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_tick && (r_bitCnt == BIT_LAST))
          w_stateNext = (PAR_W != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_tick) w_stateNext = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          if (w_cs) begin
            if (r_parMis)             w_setParityErr = 1'b1;
            else if (w_full && !w_pop) w_setOverflow = 1'b1;
            else                       w_push        = 1'b1;
            w_stateNext = ST_IDLE;
          end else begin
            w_setFrameErr = 1'b1;
            w_stateNext   = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (w_cs) w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Synchronizer, bit timing counters, payload shift register, parity
  // tracking and the registered one-cycle error pulses.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_cnt       <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parMis    <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync1     <= i_c;
      r_sync2     <= r_sync1;
      r_parityErr <= w_setParityErr;
      r_frameErr  <= w_setFrameErr;
      r_overflow  <= w_setOverflow;

      if ((r_state == ST_IDLE) || w_tick) r_cnt <= '0;
      else                                r_cnt <= r_cnt + CNT_W'(1);

      if ((r_state == ST_START) && w_tick) begin
        r_bitCnt <= '0;
        r_parMis <= 1'b0;
      end

      // Shifting in from the top leaves the first data bit in bit 0.
      if ((r_state == ST_DATA) && w_tick) begin
        r_shift  <= {w_cs, r_shift[DATA_BITS-1:1]};
        r_bitCnt <= r_bitCnt + BIT_W'(1);
      end

      if ((r_state == ST_PARITY) && w_tick) r_parMis <= (^r_shift) ^ w_cs;
    end
  end

  c_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wrData (r_shift),
    .o_rdData (o_rd_data),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

endmodule

// File: tb/tb_c_line_rx.sv
// ---------------------------------------------------------------------------
// tb_c_line_rx
// Drives whole serial frames on c, predicts the receive queue contents and
// the error pulses from the frame rules, and compares against the receiver.
// ---------------------------------------------------------------------------
module tb_c_line_rx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       c = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int perrCnt = 0;
  int ferrCnt = 0;
  int ovfCnt = 0;
  int expPerr = 0;
  int expFerr = 0;
  int expOvf = 0;
  logic [7:0] modelQ[$];

  c_line_rx dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_c          (c),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Every cycle an error output is high counts once, so a stretched pulse
  // shows up as an extra count.
  always @(negedge clk) begin
    if (parity_err === 1'b1) perrCnt++;
    if (frame_err === 1'b1)  ferrCnt++;
    if (overflow === 1'b1)   ovfCnt++;
  end

  // Frames are 11 bits of 16 clocks each: start, 8 data LSB first, parity, stop.
  task automatic sendFrame(input logic [7:0] data, input logic parBit, input logic stopBit);
    logic [10:0] bits;
    bits = {stopBit, parBit, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      c = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    c = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  // Reference model: outcome of one frame from the line rules alone.
  task automatic modelFrame(input logic [7:0] data, input logic parBit, input logic stopBit,
                            input bit popAtStop);
    if (!stopBit)                             expFerr++;
    else if (parBit != ^data)                 expPerr++;
    else if (modelQ.size() == 4 && !popAtStop) expOvf++;
    else                                      modelQ.push_back(data);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || parity_err !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b data=%h perr=%b ferr=%b ovf=%b, expected 0/00/0/0/0",
               rd_valid, rd_data, parity_err, frame_err, overflow);
    end
    rstn = 1'b1;
    idle(4);
  endtask

  task automatic test_good_frame();
    logic [7:0] exp;
    fork
      sendFrame(8'hA5, ^8'hA5, 1'b1);
      begin
        repeat (170) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL good_early_valid: rd_valid=%b, expected 0", rd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
          errors++;
          $display("[TB] FAIL good_first_valid: valid=%b data=%h, expected 1/a5", rd_valid, rd_data);
        end
      end
    join
    modelFrame(8'hA5, ^8'hA5, 1'b1, 1'b0);
    checks++;
    if (perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL good_errs: perr/ferr/ovf=%0d/%0d/%0d, expected %0d/%0d/%0d",
               perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL good_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL good_empty: valid=%b data=%h, expected 0/00", rd_valid, rd_data);
    end
    // A pop request while empty must leave the queue empty.
    popOne();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pop_when_empty: valid=%b, expected 0", rd_valid);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    c = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    checks++;
    if (rd_valid !== 1'b0 || perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL glitch_quiet: valid=%b perr/ferr/ovf=%0d/%0d/%0d, expected 0 %0d/%0d/%0d",
               rd_valid, perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
    sendFrame(8'h3C, ^8'h3C, 1'b1);
    modelFrame(8'h3C, ^8'h3C, 1'b1, 1'b0);
    idle(2);
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL glitch_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
  endtask

  task automatic test_parity_error();
    fork
      sendFrame(8'h01, 1'b0, 1'b1);
      begin
        repeat (170) @(posedge clk);
        #1;
        checks++;
        if (parity_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL parity_early: parity_err=%b, expected 0", parity_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (parity_err !== 1'b1) begin
          errors++;
          $display("[TB] FAIL parity_pulse: parity_err=%b, expected 1", parity_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (parity_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL parity_width: parity_err=%b, expected 0", parity_err);
        end
      end
    join
    modelFrame(8'h01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL parity_result: valid=%b perr/ferr/ovf=%0d/%0d/%0d, expected 0 %0d/%0d/%0d",
               rd_valid, perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] exp;
    sendFrame(8'h55, ^8'h55, 1'b0);
    modelFrame(8'h55, ^8'h55, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    idle(4);
    checks++;
    if (rd_valid !== 1'b0 || perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL framing_result: valid=%b perr/ferr/ovf=%0d/%0d/%0d, expected 0 %0d/%0d/%0d",
               rd_valid, perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
    sendFrame(8'h0F, ^8'h0F, 1'b1);
    modelFrame(8'h0F, ^8'h0F, 1'b1, 1'b0);
    idle(2);
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL framing_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp = 8'h10 + 8'(i);
      sendFrame(exp, ^exp, 1'b1);
      modelFrame(exp, ^exp, 1'b1, 1'b0);
      checks++;
      if (ovfCnt !== expOvf) begin
        errors++;
        $display("[TB] FAIL overflow_frame%0d: overflow count=%0d, expected %0d", i, ovfCnt, expOvf);
      end
    end
    idle(2);
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL overflow_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_empty: valid=%b, expected 0", rd_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 8'h20 + 8'(i);
      sendFrame(exp, ^exp, 1'b1);
      modelFrame(exp, ^exp, 1'b1, 1'b0);
    end
    fork
      sendFrame(8'h77, ^8'h77, 1'b1);
      begin
        repeat (170) @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== modelQ[0]) begin
          errors++;
          $display("[TB] FAIL fullpop_head: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, modelQ[0]);
        end
        popOne();
        checks++;
        if (overflow !== 1'b0 || rd_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL fullpop_no_overflow: overflow=%b valid=%b, expected 0/1", overflow, rd_valid);
        end
      end
    join
    void'(modelQ.pop_front());
    modelFrame(8'h77, ^8'h77, 1'b1, 1'b1);
    checks++;
    if (ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL fullpop_ovf_count: overflow count=%0d, expected %0d", ovfCnt, expOvf);
    end
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL fullpop_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fullpop_empty: valid=%b, expected 0", rd_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    sendFrame(8'h99, ^8'h99, 1'b1);
    modelFrame(8'h99, ^8'h99, 1'b1, 1'b0);
    // Start bit and two data bits, then reset while the decoder is in DATA.
    c = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    c = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    c = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    c = 1'b1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    modelQ.delete();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || parity_err !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: valid=%b data=%h perr=%b ferr=%b ovf=%b, expected 0/00/0/0/0",
               rd_valid, rd_data, parity_err, frame_err, overflow);
    end
    idle(40);
    checks++;
    if (rd_valid !== 1'b0 || perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL midreset_quiet: valid=%b perr/ferr/ovf=%0d/%0d/%0d, expected 0 %0d/%0d/%0d",
               rd_valid, perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
    sendFrame(8'hC3, ^8'hC3, 1'b1);
    modelFrame(8'hC3, ^8'hC3, 1'b1, 1'b0);
    idle(2);
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL midreset_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    int         mode;
    for (int i = 0; i < 10; i++) begin
      data    = 8'($urandom);
      mode    = int'($urandom_range(0, 9));
      parBit  = (mode == 7) ? ~(^data) : ^data;
      stopBit = (mode >= 8) ? 1'b0 : 1'b1;
      sendFrame(data, parBit, stopBit);
      modelFrame(data, parBit, stopBit, 1'b0);
      if (!stopBit) idle(4);
      else          idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    checks++;
    if (perrCnt !== expPerr || ferrCnt !== expFerr || ovfCnt !== expOvf) begin
      errors++;
      $display("[TB] FAIL random_errs: perr/ferr/ovf=%0d/%0d/%0d, expected %0d/%0d/%0d",
               perrCnt, ferrCnt, ovfCnt, expPerr, expFerr, expOvf);
    end
    while (modelQ.size() > 0) begin
      exp = modelQ.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL random_drain: valid=%b data=%h, expected 1/%h", rd_valid, rd_data, exp);
      end
      popOne();
    end
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL random_empty: valid=%b, expected 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_parity_error();
    test_framing_error();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c_line_rx.md
# c_line_rx

Serial receiver for the 1-bit `c` line driven by DARTH_VADER. It oversamples `c`, decodes start/data/parity/stop frames, and queues received words in a small first-word-fall-through FIFO that the bench or a downstream checker drains. It sits at the observing end of DARTH_VADER's output, in the same clock domain as the core.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
- DATA_BITS, 8, payload bits per frame, LSB first
- PARITY_EN, 1, 1 = even parity bit present after the data bits; 0 = no parity bit
- FIFO_DEPTH, 4, receive queue entries; power of 2, >= 2
- clk  in  1  single system clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- c  in  1  serial line from DARTH_VADER, idle high
- rd_en  in  1  pop request; honoured only while rd_valid = 1
- rd_data  out  DATA_BITS  head of FIFO; 0 when empty
- rd_valid  out  1  FIFO not empty
- parity_err  out  1  one-cycle pulse: frame dropped, parity mismatch
- frame_err  out  1  one-cycle pulse: frame dropped, stop bit read as 0
- overflow  out  1  one-cycle pulse: good frame dropped, FIFO full

## Operation
- `c` passes through a 2-flop synchronizer (both flops reset to 1). `cs` is the synchronized value; the FSM sees only `cs`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on the first cycle T0 in which `cs` = 0, go to START and clear the bit counter.
- Every bit k is sampled at cycle T0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT. Bit 0 is the start bit, bits 1..DATA_BITS are data, then parity (if PARITY_EN), then stop.
- START sample = 1: treat as a glitch. Return to IDLE with no error. START sample = 0: go to DATA.
- DATA: shift each sample in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: record mismatch = (XOR of data bits) ^ sample.
- STOP, sample = 1:
  - parity mismatch: pulse parity_err, drop the frame.
  - else FIFO full with no pop this cycle: pulse overflow, drop the frame.
  - else push the word.
  - Then go to IDLE.
- STOP, sample = 0: pulse frame_err, drop the frame, go to WAIT_HIGH. Parity is not also reported.
- WAIT_HIGH: stay until `cs` = 1, then go to IDLE. This prevents false starts during a break.
- FIFO is first-word-fall-through. A pop happens when rd_en and rd_valid are both 1. rd_en while empty is ignored.
- Push and pop in the same cycle while full: both succeed. There is no overflow, and the count is unchanged.
- Push and pop in the same cycle while holding 1 entry: rd_valid stays 1 and rd_data shows the new word on the next cycle.
- Pointers are log2(FIFO_DEPTH) bits plus a wrap bit. Full = indices equal and wrap bits differ.
- Reset (any state, including mid-frame) puts:
  - state = IDLE, counters = 0, shift register = 0;
  - FIFO pointers = 0, so rd_valid = 0 and rd_data = 0;
  - all error pulses = 0;
  - synchronizer = 1.
  - FIFO storage is not reset.

## Timing
- Pin to `cs`: 2 cycles.
- Push is registered in the stop-sample cycle Ts. rd_valid = 1 and rd_data are valid from cycle Ts+1.
- Ts = T0 + CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + 1)*CLKS_PER_BIT. With defaults, Ts = T0 + 168.
- Error pulses are asserted in cycle Ts+1 for exactly one cycle. A parity or overflow error is reported at the stop sample of that frame, not at the parity sample.
- A pop at cycle t updates rd_data/rd_valid at t+1.
- The earliest next start is detected at Ts+1. Back-to-back frames with no idle gap are received.

## Structure
- Package `c_rx_pkg`:
  - FSM state enum;
  - default bit-timing and width constants;
  - helper function for the parity width.
- Sub-module `c_rx_fifo`: parameterised FWFT FIFO with push, pop, full, empty, and registered pointers. The top level holds the synchronizer, FSM, bit counters, and shift register.

## Test plan
All scenarios use default parameters.
- Good frame: send 0xA5, parity 0, stop 1. Expect rd_valid at T0+169, rd_data = 0xA5, no error pulses. Pop once, then rd_valid = 0.
- Glitch: hold c low for 4 cycles, then high. Expect no push, no error pulse, FSM back in IDLE. A following frame 0x3C is received correctly.
- Parity error: send 0x01 with parity bit 0. Expect parity_err for one cycle at T0+169, FIFO empty.
- Framing error: send 0x55 with stop 0, hold c low 50 more cycles, then send 0x0F. Expect:
  - frame_err once;
  - no start detected during the low hold;
  - 0x0F received correctly.
- Overflow and ordering: send 0x10..0x14 back-to-back with no reads. Expect overflow on the fifth frame only. Four pops return 0x10, 0x11, 0x12, 0x13, then rd_valid = 0.
- Full plus simultaneous pop: with the FIFO full, assert rd_en in the cycle of a good stop sample. Expect no overflow, still full. Reads return the remaining 3 old words, then the new word.
- Reset mid-frame: drive rstn low for 1 cycle during DATA. Expect:
  - rd_valid = 0, rd_data = 0, no error pulses;
  - the next complete frame is received correctly.
